pll_dyn_reconfig_ctrl: RTL and testbench
========================================

// Module: pll_dyn_reconfig_ctrl
// PURPOSE
//  Drives the dynamic-control side of the PLLVR: the IDSEL/FBDSEL/ODSEL and RESET inputs, and reads back LOCK.
//  Sequences a divider change: validate, apply, hold the PLL in reset, wait for lock, confirm it is stable, then acknowledge.
//  Also watches for lock loss and re-runs the lock sequence on its own.
//  Sits in the clkin (27 MHz) domain, between user logic and the PLL wrapper.
// PARAMETERS
//  IDIV_DEF      9        input divider applied at reset (1..64)
//  FBDIV_DEF     20       feedback divider applied at reset (1..64)
//  ODIV_DEF      16       output divider applied at reset (even, 2..128)
//  RST_CYCLES    16       clkin cycles that pll_reset is held per attempt (>=2)
//  LOCK_TIMEOUT  27000    clkin cycles allowed for lock to rise, per attempt
//  LOCK_STABLE   256      consecutive synced-lock-high cycles required to accept lock
//  MAX_RETRY     3        extra attempts after the first timeout before an error is declared
// PORTS
//  clkin      in   1  reference clock (PLL input clock)
//  rst        in   1  synchronous, active-high reset
//  req        in   1  request a reconfiguration; sampled only in IDLE
//  idiv       in   7  requested input divider
//  fbdiv      in   7  requested feedback divider
//  odiv       in   8  requested output divider
//  ack        out  1  one-cycle pulse: request finished (success or error)
//  err        out  2  valid with ack: 0 ok, 1 bad params, 2 lock timeout
//  busy       out  1  high in every state except IDLE and ERROR
//  locked     out  1  lock accepted and currently held
//  lock_lost  out  1  sticky; set on a loss of synced lock while locked; cleared by req or rst
//  pll_lock   in   1  PLL LOCK (asynchronous to clkin)
//  pll_reset  out  1  to PLL RESET
//  idsel      out  6  to PLL IDSEL  = ~(idiv-1)
//  fbdsel     out  6  to PLL FBDSEL = ~(fbdiv-1)
//  odsel      out  6  to PLL ODSEL  = ~(odiv/2-1)
// BEHAVIOUR
//  - rst: {id,fbd,od}sel encode the *_DEF values; pll_reset=1; ack=0; err=0; locked=0; lock_lost=0; retry count=0; state=APPLY.
//    Leaving reset, the block runs the lock sequence with the defaults; no ack is issued for that sequence.
//  - The DSEL outputs are registered and change only on entry to APPLY. They are constant at all other times.
//  - pll_lock passes through a 2-FF synchroniser; all lock decisions use the synced value (+2 cycles of latency).
//  - IDLE:
//    - busy=0. locked=1, except after an error, when locked=0.
//    - req=1 is checked in the same cycle.
//      - idiv or fbdiv outside 1..64, or odiv odd or outside 2..128: next cycle ack=1, err=1, state stays IDLE,
//        DSEL outputs and pll_reset are unchanged.
//      - Otherwise: latch the values, clear lock_lost, go to APPLY.
//    - Synced lock falling while locked=1: set lock_lost, locked=0, go to APPLY with the current values (no ack).
//  - APPLY (1 cycle): drive the new DSEL values, pll_reset=1, locked=0. Go to HOLD_RST.
//  - HOLD_RST: keep pll_reset=1 for RST_CYCLES cycles, counting the APPLY cycle, then pll_reset=0. Go to WAIT_LOCK.
//  - WAIT_LOCK:
//    - Timeout counter starts at 0.
//    - Synced lock=1: go to STABLE.
//    - Counter reaches LOCK_TIMEOUT-1:
//      - retry count < MAX_RETRY: increment it and go to APPLY.
//      - otherwise: go to ERROR.
//  - STABLE:
//    - Counts consecutive synced-lock-high cycles.
//    - A low sample returns to WAIT_LOCK. The timeout counter is NOT reset.
//    - Reaching LOCK_STABLE: locked=1, retry count=0, go to IDLE.
//      - If the sequence came from a req: ack=1, err=0, in the cycle IDLE is entered.
//  - ERROR:
//    - Came from a req: ack=1, err=2 on entry (1 cycle).
//    - pll_reset=0; DSEL outputs are kept; busy=0; locked=0.
//    - Leaves only on a valid req (same checks as IDLE) or on rst.
//  - A req while busy=1 is ignored: no ack, no queuing.
//  - Exactly one ack per accepted or rejected req. ack never coincides with rst.
//  - Counter widths are $clog2 of their parameter. Counters saturate and never wrap.
//  - rst mid-sequence aborts it at once; behaviour matches power-up, and no ack is issued.
// STRUCTURE
//  - Package pll_ctrl_pkg:
//    - state enum {IDLE, APPLY, HOLD_RST, WAIT_LOCK, STABLE, ERROR};
//    - err codes ERR_OK / ERR_PARAM / ERR_TIMEOUT;
//    - functions enc_div(n)=~(n-1) and enc_odiv(n)=~(n/2-1), each returning 6 bits, plus a param_valid check.
//  - One sub-module, pll_lock_filter: the 2-FF synchroniser plus the stability counter.
//    Outputs lock_sync and lock_stable; clr input restarts the count.
// TESTING
//  - Bench drives clkin at 27 MHz. A PLL model asserts lock a programmable N cycles after pll_reset falls.
//  1. rst, then lock model N=100 -> pll_reset high 16 cycles; locked=1 at 16+100+2+256 (+-1); no ack;
//     idsel=6'b110111, fbdsel=6'b101100, odsel=6'b111000.
//  2. req idiv=4 fbdiv=32 odiv=8 -> idsel=6'b111100, fbdsel=6'b100000, odsel=6'b111100;
//     then ack=1, err=0 once; busy low after.
//  3. req odiv=7, then req idiv=0 -> each gives ack with err=1 one cycle later; DSEL outputs unchanged; pll_reset stays 0.
//  4. Lock model never locks -> 4 attempts (1+MAX_RETRY), each with 16 reset cycles;
//     then ack, err=2, locked=0; state ERROR; a valid req afterwards recovers.
//  5. Drop pll_lock for 1 cycle in IDLE -> lock_lost=1, automatic re-lock, locked back to 1, no ack;
//     the next req clears lock_lost.
//  6. Assert rst during WAIT_LOCK and again during STABLE -> DSEL outputs return to the defaults;
//     sequence restarts; no ack; a req made during busy is ignored.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and divider-encoding helpers for the PLLVR dynamic-reconfiguration controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        HOLD_RST,
        WAIT_LOCK,
        STABLE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_PARAM   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } dsel_t;

    // PLL select inputs are the inverted (divider - 1) codes
    function automatic logic [5:0] enc_div(input logic [6:0] n);
        return ~(6'(n - 7'd1));
    endfunction

    function automatic logic [5:0] enc_odiv(input logic [7:0] n);
        return ~(6'((n >> 1) - 8'd1));
    endfunction

    function automatic logic param_valid(input logic [6:0] idiv, input logic [6:0] fbdiv,
                                         input logic [7:0] odiv);
        return (idiv != 7'd0) && (idiv <= 7'd64) &&
               (fbdiv != 7'd0) && (fbdiv <= 7'd64) &&
               !odiv[0] && (odiv != 8'd0) && (odiv <= 8'd128);
    endfunction

    function automatic dsel_t enc_cfg(input logic [6:0] idiv, input logic [6:0] fbdiv,
                                      input logic [7:0] odiv);
        return '{idsel: enc_div(idiv), fbdsel: enc_div(fbdiv), odsel: enc_odiv(odiv)};
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL lock and counts consecutive high samples of it.
module pll_lock_filter #(
    parameter int unsigned LOCK_STABLE = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_async,
    input  logic clr,
    output logic lock_sync,
    output logic lock_stable
);

    localparam int unsigned CW = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;

    logic          meta;
    logic [CW-1:0] cnt;

    // lock_stable rises on the LOCK_STABLE-th consecutive high sample; count saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            meta        <= 1'b0;
            lock_sync   <= 1'b0;
            cnt         <= '0;
            lock_stable <= 1'b0;
        end else begin
            meta      <= lock_async;
            lock_sync <= meta;
            if (clr || !lock_sync) begin
                cnt         <= '0;
                lock_stable <= 1'b0;
            end else if (cnt < CW'(LOCK_STABLE - 1)) begin
                cnt         <= cnt + CW'(1);
                lock_stable <= 1'b0;
            end else begin
                lock_stable <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_dyn_reconfig_ctrl.sv
// Sequences PLLVR divider changes: validate, apply, hold reset, wait for lock, qualify, acknowledge.
module pll_dyn_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned IDIV_DEF     = 9,
    parameter int unsigned FBDIV_DEF    = 20,
    parameter int unsigned ODIV_DEF     = 16,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 27000,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] idiv,
    input  logic [6:0] fbdiv,
    input  logic [7:0] odiv,
    output logic       ack,
    output logic [1:0] err,
    output logic       busy,
    output logic       locked,
    output logic       lock_lost,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel
);

    localparam int unsigned RCW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TCW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned RTW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    localparam dsel_t DSEL_DEF = '{idsel:  enc_div(7'(IDIV_DEF)),
                                   fbdsel: enc_div(7'(FBDIV_DEF)),
                                   odsel:  enc_odiv(8'(ODIV_DEF))};

    state_t           state, state_d;
    dsel_t            dsel_q, dsel_d;
    logic [RCW-1:0]   rst_cnt, rst_cnt_d;
    logic [TCW-1:0]   to_cnt, to_cnt_d;
    logic [RTW-1:0]   retry, retry_d;
    logic             from_req, from_req_d;
    logic             ack_d, busy_d, locked_d, lock_lost_d, pll_reset_d;
    logic [1:0]       err_d;
    logic             lock_sync, lock_stable, lock_clr_c;

    // Stability count runs only while the FSM is looking for lock
    assign lock_clr_c = !((state == WAIT_LOCK) || (state == STABLE));

    pll_lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk        (clkin),
        .rst        (rst),
        .lock_async (pll_lock),
        .clr        (lock_clr_c),
        .lock_sync  (lock_sync),
        .lock_stable(lock_stable)
    );

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= APPLY;
            dsel_q    <= DSEL_DEF;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            retry     <= '0;
            from_req  <= 1'b0;
            ack       <= 1'b0;
            err       <= ERR_OK;
            busy      <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            pll_reset <= 1'b1;
        end else begin
            state     <= state_d;
            dsel_q    <= dsel_d;
            rst_cnt   <= rst_cnt_d;
            to_cnt    <= to_cnt_d;
            retry     <= retry_d;
            from_req  <= from_req_d;
            ack       <= ack_d;
            err       <= err_d;
            busy      <= busy_d;
            locked    <= locked_d;
            lock_lost <= lock_lost_d;
            pll_reset <= pll_reset_d;
        end
    end

    always_comb begin
        state_d     = state;
        dsel_d      = dsel_q;
        rst_cnt_d   = rst_cnt;
        to_cnt_d    = to_cnt;
        retry_d     = retry;
        from_req_d  = from_req;
        ack_d       = 1'b0;
        err_d       = err;
        locked_d    = locked;
        lock_lost_d = lock_lost;
        pll_reset_d = pll_reset;

        case (state)
            IDLE, ERROR: begin
                if (req) begin
                    if (param_valid(idiv, fbdiv, odiv)) begin
                        state_d     = APPLY;
                        dsel_d      = enc_cfg(idiv, fbdiv, odiv);
                        from_req_d  = 1'b1;
                        retry_d     = '0;
                        lock_lost_d = 1'b0;
                        locked_d    = 1'b0;
                        pll_reset_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        err_d = ERR_PARAM;
                    end
                end else if ((state == IDLE) && locked && !lock_sync) begin
                    // Autonomous re-lock with the current dividers; nobody to acknowledge
                    state_d     = APPLY;
                    from_req_d  = 1'b0;
                    lock_lost_d = 1'b1;
                    locked_d    = 1'b0;
                    pll_reset_d = 1'b1;
                end
            end
            APPLY: begin
                state_d   = HOLD_RST;
                rst_cnt_d = RCW'(1);
                to_cnt_d  = '0;
            end
            HOLD_RST: begin
                if (rst_cnt >= RCW'(RST_CYCLES - 1)) begin
                    state_d     = WAIT_LOCK;
                    pll_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt + RCW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = STABLE;
                end else if (to_cnt >= TCW'(LOCK_TIMEOUT - 1)) begin
                    if (retry < RTW'(MAX_RETRY)) begin
                        retry_d     = retry + RTW'(1);
                        state_d     = APPLY;
                        pll_reset_d = 1'b1;
                    end else begin
                        state_d = ERROR;
                        if (from_req) begin
                            ack_d = 1'b1;
                            err_d = ERR_TIMEOUT;
                        end
                    end
                end else begin
                    to_cnt_d = to_cnt + TCW'(1);
                end
            end
            STABLE: begin
                // Timeout budget keeps running across a lock glitch
                if (!lock_sync) begin
                    state_d = WAIT_LOCK;
                end else if (lock_stable) begin
                    state_d  = IDLE;
                    locked_d = 1'b1;
                    retry_d  = '0;
                    if (from_req) begin
                        ack_d = 1'b1;
                        err_d = ERR_OK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = !((state_d == IDLE) || (state_d == ERROR));
    end

    assign idsel  = dsel_q.idsel;
    assign fbdsel = dsel_q.fbdsel;
    assign odsel  = dsel_q.odsel;

endmodule

// File: tb/tb_pll_dyn_reconfig_ctrl.sv
// Directed and randomized checks of pll_dyn_reconfig_ctrl against a behavioural PLL and reference model.
module tb_pll_dyn_reconfig_ctrl;

    localparam int unsigned RST_CYC = 16;
    localparam int unsigned TMO     = 400;
    localparam int unsigned STAB    = 256;
    localparam int unsigned RETRY   = 3;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [6:0] idiv = '0;
    logic [6:0] fbdiv = '0;
    logic [7:0] odiv = '0;
    logic       ack, busy, locked, lock_lost, pll_reset;
    logic [1:0] err;
    logic       pll_lock = 1'b0;
    logic [5:0] idsel, fbdsel, odsel;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt = 0, pulses = 0, bad_len = 0, run_len = 0;
    int lock_delay = 100, cur_delay = 100, lk_cnt = 0;
    bit never_lock = 0, cur_never = 0, force_drop = 0;
    int exp_id = 55, exp_fb = 44, exp_od = 56;
    bit exp_locked = 0;

    pll_dyn_reconfig_ctrl #(
        .IDIV_DEF(9), .FBDIV_DEF(20), .ODIV_DEF(16), .RST_CYCLES(RST_CYC),
        .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STAB), .MAX_RETRY(RETRY)
    ) dut (
        .clkin(clkin), .rst(rst), .req(req), .idiv(idiv), .fbdiv(fbdiv), .odiv(odiv),
        .ack(ack), .err(err), .busy(busy), .locked(locked), .lock_lost(lock_lost),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel)
    );

    always #18.518ns clkin = ~clkin;

    // PLL model: lock rises cur_delay cycles after RESET falls; settings latched while in reset
    always @(negedge clkin) begin
        if (pll_reset) begin
            lk_cnt    = 0;
            cur_delay = lock_delay;
            cur_never = never_lock;
            pll_lock  = 1'b0;
        end else begin
            if (lk_cnt < cur_delay) lk_cnt++;
            pll_lock = !cur_never && (lk_cnt >= cur_delay) && !force_drop;
        end
    end

    always @(posedge clkin) begin
        if (ack) ack_cnt++;
        if (pll_reset) run_len++;
        else if (run_len != 0) begin
            pulses++;
            if (run_len != RST_CYC) bad_len++;
            run_len = 0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dsel(input string tag);
        check({tag, "_idsel"}, 32'(idsel), 32'(exp_id));
        check({tag, "_fbdsel"}, 32'(fbdsel), 32'(exp_fb));
        check({tag, "_odsel"}, 32'(odsel), 32'(exp_od));
    endtask

    task automatic set_model(input int d, input bit nl);
        @(posedge clkin);
        lock_delay = d;
        never_lock = nl;
    endtask

    task automatic do_req(input int i, input int f, input int o, input string tag);
        bit valid, ok;
        int base_ack, exp_err;
        valid = (i >= 1) && (i <= 64) && (f >= 1) && (f <= 64) &&
                (o >= 2) && (o <= 128) && ((o % 2) == 0);
        @(negedge clkin);
        idiv = 7'(i); fbdiv = 7'(f); odiv = 8'(o); req = 1'b1;
        base_ack = ack_cnt;
        @(negedge clkin);
        req = 1'b0;
        if (!valid) begin
            check({tag, "_rej_ack"}, 32'(ack), 1);
            check({tag, "_rej_err"}, 32'(err), 1);
            check({tag, "_rej_pllrst"}, 32'(pll_reset), 0);
            check({tag, "_rej_busy"}, 32'(busy), 0);
            check({tag, "_rej_locked"}, 32'(locked), 32'(exp_locked));
            check_dsel({tag, "_rej"});
        end else begin
            exp_id = 64 - i;
            exp_fb = 64 - f;
            exp_od = 64 - o / 2;
            exp_err = never_lock ? 2 : 0;
            check_dsel({tag, "_apply"});
            check({tag, "_apply_pllrst"}, 32'(pll_reset), 1);
            check({tag, "_apply_busy"}, 32'(busy), 1);
            check({tag, "_apply_lostclr"}, 32'(lock_lost), 0);
            ok = 0;
            for (int k = 0; k < 3000; k++) begin
                if (ack) begin ok = 1; break; end
                @(negedge clkin);
            end
            check({tag, "_ack_seen"}, 32'(ok), 1);
            check({tag, "_err"}, 32'(err), 32'(exp_err));
            exp_locked = !never_lock;
            check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
            check({tag, "_busy_done"}, 32'(busy), 0);
            check({tag, "_pllrst_done"}, 32'(pll_reset), 0);
            check_dsel({tag, "_done"});
        end
        @(negedge clkin);
        check({tag, "_ack_pulse"}, 32'(ack), 0);
        check({tag, "_ack_count"}, 32'(ack_cnt - base_ack), 1);
    endtask

    initial begin
        int hi, cyc, base, bp, bb, i, f, o;
        bit ok;

        // 1: power-up sequence with defaults
        repeat (3) @(negedge clkin);
        check("rst_pllrst", 32'(pll_reset), 1);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_lost", 32'(lock_lost), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_idsel", 32'(idsel), 32'(6'b110111));
        check("rst_fbdsel", 32'(fbdsel), 32'(6'b101100));
        check("rst_odsel", 32'(odsel), 32'(6'b111000));
        rst = 1'b0;
        hi = 1; cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clkin); cyc++;
            if (pll_reset) hi++; else break;
        end
        check("pwr_rst_pulse", 32'(hi), RST_CYC);
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (locked) begin ok = 1; break; end
            @(negedge clkin); cyc++;
        end
        check("pwr_lock_seen", 32'(ok), 1);
        check("pwr_lock_cycle", (cyc >= 373 && cyc <= 375) ? 32'd374 : 32'(cyc), 374);
        check("pwr_no_ack", 32'(ack_cnt), 0);
        check("pwr_busy", 32'(busy), 0);
        check_dsel("pwr");
        exp_locked = 1;

        // 2: valid reconfiguration
        do_req(4, 32, 8, "t2");

        // 3: rejected requests
        do_req(4, 32, 7, "t3_odd");
        do_req(0, 32, 8, "t3_zero");
        do_req(65, 32, 8, "t3_big");

        // 4: lock never arrives -> retries then timeout error, then recovery
        set_model(100, 1);
        bp = pulses; bb = bad_len;
        do_req(5, 10, 12, "t4");
        check("t4_attempts", 32'(pulses - bp), 1 + RETRY);
        check("t4_pulse_len", 32'(bad_len - bb), 0);
        do_req(0, 1, 2, "t4_rej_in_err");
        set_model(100, 0);
        do_req(9, 20, 16, "t4_recover");

        // 5: lock glitch while locked -> autonomous re-lock
        base = ack_cnt;
        @(posedge clkin); force_drop = 1;
        @(posedge clkin); force_drop = 0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clkin);
            if (lock_lost) begin ok = 1; break; end
        end
        check("t5_lost_set", 32'(ok), 1);
        check("t5_unlocked", 32'(locked), 0);
        check("t5_pllrst", 32'(pll_reset), 1);
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clkin);
            if (locked) begin ok = 1; break; end
        end
        check("t5_relock", 32'(ok), 1);
        check("t5_lost_sticky", 32'(lock_lost), 1);
        check("t5_no_ack", 32'(ack_cnt - base), 0);
        check_dsel("t5");
        do_req(2, 64, 128, "t5_clear");

        // 6: reset during WAIT_LOCK and STABLE; request while busy ignored
        base = ack_cnt;
        @(negedge clkin);
        idiv = 7'd3; fbdiv = 7'd40; odiv = 8'd20; req = 1'b1;
        @(negedge clkin); req = 1'b0;
        check("t6_idsel_new", 32'(idsel), 61);
        for (int k = 0; k < 100 && pll_reset; k++) @(negedge clkin);
        repeat (20) @(negedge clkin);
        check("t6_waiting", 32'(busy), 1);
        rst = 1'b1;
        repeat (2) @(negedge clkin);
        exp_id = 55; exp_fb = 44; exp_od = 56;
        check_dsel("t6_rst1");
        check("t6_rst1_pllrst", 32'(pll_reset), 1);
        check("t6_rst1_locked", 32'(locked), 0);
        rst = 1'b0;
        @(negedge clkin);
        idiv = 7'd2; fbdiv = 7'd2; odiv = 8'd2; req = 1'b1;
        @(negedge clkin); req = 1'b0;
        @(negedge clkin);
        check_dsel("t6_busy_req");
        for (int k = 0; k < 100 && pll_reset; k++) @(negedge clkin);
        repeat (150) @(negedge clkin);
        check("t6_stable_busy", 32'(busy), 1);
        rst = 1'b1;
        repeat (2) @(negedge clkin);
        check_dsel("t6_rst2");
        check("t6_rst2_locked", 32'(locked), 0);
        rst = 1'b0;
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clkin);
            if (locked) begin ok = 1; break; end
        end
        check("t6_relock", 32'(ok), 1);
        check("t6_no_ack", 32'(ack_cnt - base), 0);
        check_dsel("t6_final");
        exp_locked = 1;

        // Randomized requests against the reference model
        for (int n = 0; n < 8; n++) begin
            set_model(int'($urandom_range(20, 150)), 0);
            i = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 64)) : int'($urandom_range(0, 127));
            f = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 64)) : int'($urandom_range(0, 127));
            o = ($urandom_range(0, 1) == 1) ? 2 * int'($urandom_range(1, 64)) : int'($urandom_range(0, 255));
            do_req(i, f, o, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
